systolic_mm_engine_param: RTL
=============================

Name: systolic_mm_engine_param

Overview:
Parametrised output-stationary systolic matrix-multiply engine computing C = A x B (QxR times RxK, each dimension 1..SIZE). Operand matrices arrive on flattened buses and are captured on start. Internal feeders apply the diagonal skew, so the caller never sequences operands. It adds several capabilities:
- generic SIZE and DATAWIDTH
- signed mode
- accumulate-across-jobs mode
- dimension checking with an error pulse
- full-precision accumulators

Parameters:
- DATAWIDTH, 16, operand width in bits.
- SIZE, 4, array dimension (SIZE x SIZE PEs), 2..16.
- SIGNED, 0, 1 = two's-complement operands and accumulators; 0 = unsigned.
- ACCWIDTH, 2*DATAWIDTH+$clog2(SIZE)+2, accumulator/result width. The +2 absorbs accumulate mode.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- accumulate  in  1  sampled with start; 1 = keep accumulators, 0 = clear before job.
- depth_A  in  $clog2(SIZE)+1  Q, rows of A.
- width_A  in  $clog2(SIZE)+1  R, columns of A.
- depth_B  in  $clog2(SIZE)+1  rows of B; must equal width_A.
- width_B  in  $clog2(SIZE)+1  K, columns of B.
- a_flat  in  SIZE*SIZE*DATAWIDTH  A[r][c] at bits [(r*SIZE+c)*DATAWIDTH +: DATAWIDTH].
- b_flat  in  SIZE*SIZE*DATAWIDTH  B[r][c], same packing.
- dout_flat  out  SIZE*SIZE*ACCWIDTH  C[i][j] at bits [(i*SIZE+j)*ACCWIDTH +: ACCWIDTH].
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse, result valid.
- err  out  1  one-cycle pulse, start rejected.

Behaviour:

Reset (synchronous):
- State goes to IDLE.
- busy=0, done=0, err=0.
- All accumulators, operand registers, PE pipeline registers and the cycle counter are cleared to 0.
- Reset has priority over every other input in the same cycle.

State machine: IDLE -> RUN -> DONE -> IDLE.

IDLE:
- On the edge where start=1, Q/R/K/depth_B and accumulate are latched and the dimensions are validated.
- A job is invalid if any dimension is 0, any dimension is > SIZE, or depth_B != width_A.
- Invalid job: err=1 for the next cycle only, state stays IDLE, busy stays 0, accumulators are untouched.
- Valid job:
  - a_flat and b_flat are captured into internal operand registers; inputs may change afterwards.
  - Cycle counter t is set to 0.
  - If accumulate=0, all SIZE*SIZE accumulators are cleared.
  - State goes to RUN; busy=1 from the next cycle.

RUN lasts exactly Q+R+K-1 cycles, with t = 0 .. Q+R+K-2.
- Row feeder i drives A[i][t-i] when 0 <= t-i < R and i < Q, else 0.
- Column feeder j drives B[t-j][j] when 0 <= t-j < R and j < K, else 0.
- Each PE registers a_in and b_in and forwards them: a moves right, b moves down, one register per hop.
- Each PE adds a_reg*b_reg into its accumulator every cycle. The product is full 2*DATAWIDTH, sign- or zero-extended per SIGNED.
- Zero-fed operands contribute 0. PEs outside QxK therefore keep their start value: 0, or the previous value in accumulate mode.
- No saturation; the accumulator wraps modulo 2^ACCWIDTH.

DONE: lasts 1 cycle. done=1 and busy=0, then state returns to IDLE.
- Done pulse timing: done is high in the cycle Q+R+K cycles after the start-sampling edge.
- Example: Q=R=K=4 gives done at cycle 12.

dout_flat:
- Continuously reflects the accumulators.
- Valid when done=1, and stable until the next valid start.

Boundary conditions:
- start while busy or in DONE: ignored, with no err.
- start held high: a new job is accepted in the first IDLE cycle after DONE.
- reset mid-RUN: job aborted, done never pulses, dout_flat=0 the next cycle.

Test Plan:
1. SIZE=4, DATAWIDTH=16, SIGNED=0, A=I4, B=1..16 row-major, Q=R=K=4, accumulate=0 -> dout_flat equals B; done pulses once at cycle 12; busy high for cycles 1..11.
2. A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]], Q=2, R=3, K=2 -> C=[[58,64],[139,154]]; all other dout entries 0; done at cycle 7.
3. Rerun test 2 with accumulate=1 -> C=[[116,128],[278,308]]. Then rerun with accumulate=0 -> back to [[58,64],[139,154]].
4. SIGNED=1, Q=R=K=4, A all 0xFFFF (-1), B all 0x7FFF -> every C = -131068 (sign-correct in ACCWIDTH=36).
5. start with width_A=3, depth_B=2 -> err=1 for one cycle, busy=0, dout unchanged. start with depth_A=0 or 5 -> same response. start pulsed during RUN -> ignored, single done.
6. reset asserted at RUN cycle 3 of a 4x4 job -> busy=0 and dout_flat=0 next cycle, no done. A following valid start completes with the correct result.

Source files
------------

// File: rtl/systolic_mm_engine_param.sv
// Output-stationary systolic matrix-multiply engine: C = A x B, with the operands
// captured on start and skewed into the SIZE x SIZE PE array by internal feeders.
module systolic_mm_engine_param #(
    parameter int DATAWIDTH = 16,
    parameter int SIZE      = 4,
    parameter int SIGNED    = 0,
    parameter int ACCWIDTH  = 2*DATAWIDTH + $clog2(SIZE) + 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            accumulate,
    input  logic [$clog2(SIZE):0]           depth_A,
    input  logic [$clog2(SIZE):0]           width_A,
    input  logic [$clog2(SIZE):0]           depth_B,
    input  logic [$clog2(SIZE):0]           width_B,
    input  logic [SIZE*SIZE*DATAWIDTH-1:0]  a_flat,
    input  logic [SIZE*SIZE*DATAWIDTH-1:0]  b_flat,
    output logic [SIZE*SIZE*ACCWIDTH-1:0]   dout_flat,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int DIMW = $clog2(SIZE) + 1;
    localparam int TW   = $clog2(3*SIZE);
    localparam int IW   = $clog2(SIZE);
    localparam int PW   = 2*DATAWIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     t;
    logic [DIMW-1:0]   q_r, r_r, k_r;
    logic              err_q;
    logic              dims_ok, accept, last_t;

    logic [DATAWIDTH-1:0] a_op   [SIZE][SIZE];
    logic [DATAWIDTH-1:0] b_op   [SIZE][SIZE];
    logic [DATAWIDTH-1:0] a_feed [SIZE];
    logic [DATAWIDTH-1:0] b_feed [SIZE];
    logic [DATAWIDTH-1:0] a_in   [SIZE][SIZE];
    logic [DATAWIDTH-1:0] b_in   [SIZE][SIZE];
    logic [DATAWIDTH-1:0] a_pipe [SIZE][SIZE];
    logic [DATAWIDTH-1:0] b_pipe [SIZE][SIZE];
    logic [ACCWIDTH-1:0]  prod   [SIZE][SIZE];
    logic [ACCWIDTH-1:0]  acc    [SIZE][SIZE];

    // depth_B must match width_A, so its range is covered by width_A's checks
    assign dims_ok = (depth_A != '0) && (width_A != '0) && (width_B != '0)
                  && (depth_A <= DIMW'(SIZE)) && (width_A <= DIMW'(SIZE))
                  && (width_B <= DIMW'(SIZE)) && (depth_B == width_A);
    assign accept  = (state == S_IDLE) && start && dims_ok;
    assign last_t  = (t == TW'(q_r) + TW'(r_r) + TW'(k_r) - TW'(2));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last_t) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            t     <= '0;
            q_r   <= '0;
            r_r   <= '0;
            k_r   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= (state == S_IDLE) && start && !dims_ok;
            if (accept) begin
                q_r <= depth_A;
                r_r <= width_A;
                k_r <= width_B;
                t   <= '0;
            end else if (state == S_RUN) begin
                t <= t + TW'(1);
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign err  = err_q;

    always_ff @(posedge clk) begin
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                if (reset) begin
                    a_op[r][c] <= '0;
                    b_op[r][c] <= '0;
                end else if (accept) begin
                    a_op[r][c] <= a_flat[(r*SIZE+c)*DATAWIDTH +: DATAWIDTH];
                    b_op[r][c] <= b_flat[(r*SIZE+c)*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
    end

    // Diagonal skew: row/column i starts i cycles late; out-of-range slots feed zero
    always_comb begin
        logic [TW-1:0] idx;
        idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            a_feed[i] = '0;
            b_feed[i] = '0;
            idx = t - TW'(i);
            if (state == S_RUN && t >= TW'(i) && idx < TW'(r_r)) begin
                if (TW'(i) < TW'(q_r)) a_feed[i] = a_op[i][idx[IW-1:0]];
                if (TW'(i) < TW'(k_r)) b_feed[i] = b_op[idx[IW-1:0]][i];
            end
        end
    end

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
            if (gj == 0) begin : g_afeed
                assign a_in[gi][gj] = a_feed[gi];
            end else begin : g_ahop
                assign a_in[gi][gj] = a_pipe[gi][gj-1];
            end
            if (gi == 0) begin : g_bfeed
                assign b_in[gi][gj] = b_feed[gj];
            end else begin : g_bhop
                assign b_in[gi][gj] = b_pipe[gi-1][gj];
            end
            if (SIGNED != 0) begin : g_smul
                logic signed [PW-1:0] p;
                assign p = PW'($signed(a_pipe[gi][gj])) * PW'($signed(b_pipe[gi][gj]));
                assign prod[gi][gj] = ACCWIDTH'(p);
            end else begin : g_umul
                logic [PW-1:0] p;
                assign p = PW'(a_pipe[gi][gj]) * PW'(b_pipe[gi][gj]);
                assign prod[gi][gj] = ACCWIDTH'(p);
            end
            assign dout_flat[(gi*SIZE+gj)*ACCWIDTH +: ACCWIDTH] = acc[gi][gj];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (reset || accept) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                end else begin
                    a_pipe[i][j] <= a_in[i][j];
                    b_pipe[i][j] <= b_in[i][j];
                end
                if (reset || (accept && !accumulate))
                    acc[i][j] <= '0;
                else if (state == S_RUN)
                    acc[i][j] <= acc[i][j] + prod[i][j];
            end
        end
    end

endmodule
